// File: rtl/riscv_alu_seq.sv
// Execute-stage integer ALU: single-cycle ops plus multi-cycle radix-2 restoring divide/remainder.
// Define RISCV_ALU_DIV_EARLY_OUT_EN to skip leading-zero iterations of the dividend.
module riscv_alu_seq #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1,
  localparam int ALU_OP_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [WIDTH-1:0]        operand_a_i,
  input  logic [WIDTH-1:0]        operand_b_i,
  output logic [WIDTH-1:0]        result_o,
  output logic                    comparison_result_o,
  output logic                    ready_o,
  input  logic                    ex_ready_i
);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 7'b0011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 7'b0011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 7'b0101111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 7'b0101110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 7'b0010101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 7'b0100100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 7'b0100101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 7'b0100111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 7'b0000000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 7'b0000001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 7'b0000010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 7'b0000011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 7'b0001010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 7'b0001011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 7'b0001100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 7'b0001101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;

  logic             is_div_op;
  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;

  assign is_div_op  = (operator_i == ALU_DIVU) || (operator_i == ALU_DIV) ||
                      (operator_i == ALU_REMU) || (operator_i == ALU_REM);
  assign div_signed = (operator_i == ALU_DIV) || (operator_i == ALU_REM);
  assign a_neg      = div_signed && operand_a_i[WIDTH-1];
  assign b_neg      = div_signed && operand_b_i[WIDTH-1];
  assign abs_a      = a_neg ? -operand_a_i : operand_a_i;
  assign abs_b      = b_neg ? -operand_b_i : operand_b_i;
  assign shamt      = operand_b_i[SH_W-1:0];

  // Dividend bits stream out of the top of quot while quotient bits fill in at the bottom.
  assign partial = {rem, quot[WIDTH-1]};
  assign trial   = partial - {1'b0, divisor};

`ifdef RISCV_ALU_DIV_EARLY_OUT_EN
  function automatic logic [CNT_W-1:0] clz(input logic [WIDTH-1:0] v);
    clz = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) clz = CNT_W'(WIDTH - 1 - i);
  endfunction

  logic [CNT_W-1:0] lead_zeros;
  assign lead_zeros = clz(abs_a);
`endif

  always_comb begin
    result_o            = '0;
    comparison_result_o = 1'b0;
    ready_o             = 1'b1;
    case (state)
      IDLE: begin
        if (enable_i) begin
          case (operator_i)
            ALU_ADD:  result_o = operand_a_i + operand_b_i;
            ALU_SUB:  result_o = operand_a_i - operand_b_i;
            ALU_AND:  result_o = operand_a_i & operand_b_i;
            ALU_OR:   result_o = operand_a_i | operand_b_i;
            ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
            ALU_SLL:  result_o = operand_a_i << shamt;
            ALU_SRL:  result_o = operand_a_i >> shamt;
            ALU_SRA:  result_o = $signed(operand_a_i) >>> shamt;
            ALU_EQ:   comparison_result_o = (operand_a_i == operand_b_i);
            ALU_NE:   comparison_result_o = (operand_a_i != operand_b_i);
            ALU_LTS:  comparison_result_o = ($signed(operand_a_i) < $signed(operand_b_i));
            ALU_LTU:  comparison_result_o = (operand_a_i < operand_b_i);
            ALU_GES:  comparison_result_o = ($signed(operand_a_i) >= $signed(operand_b_i));
            ALU_GEU:  comparison_result_o = (operand_a_i >= operand_b_i);
            ALU_SLTS: begin
              comparison_result_o = ($signed(operand_a_i) < $signed(operand_b_i));
              result_o = WIDTH'(comparison_result_o);
            end
            ALU_SLTU: begin
              comparison_result_o = (operand_a_i < operand_b_i);
              result_o = WIDTH'(comparison_result_o);
            end
            ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM: ready_o = 1'b0;
            default: ;
          endcase
          if (operator_i == ALU_EQ || operator_i == ALU_NE || operator_i == ALU_LTS ||
              operator_i == ALU_LTU || operator_i == ALU_GES || operator_i == ALU_GEU)
            result_o = {WIDTH{comparison_result_o}};
        end
      end
      DIVIDE: ready_o = 1'b0;
      FINISH: begin
        if (is_rem) result_o = neg_r ? -rem : rem;
        else        result_o = neg_q ? -quot : quot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      quot    <= '0;
      rem     <= '0;
      divisor <= '0;
      is_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i && is_div_op) begin
            is_rem  <= (operator_i == ALU_REMU) || (operator_i == ALU_REM);
            divisor <= abs_b;
            rem     <= '0;
            if (operand_b_i == '0) begin
              // Special results are stored final, so sign correction is disabled.
              quot  <= '1;
              rem   <= operand_a_i;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FINISH;
            end else if (div_signed && operand_a_i == MIN_VAL && operand_b_i == '1) begin
              quot  <= MIN_VAL;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FINISH;
            end else begin
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
`ifdef RISCV_ALU_DIV_EARLY_OUT_EN
              if (abs_a == '0) begin
                quot  <= '0;
                state <= FINISH;
              end else begin
                quot  <= abs_a << lead_zeros;
                cnt   <= CNT_W'(WIDTH) - lead_zeros;
                state <= DIVIDE;
              end
`else
              quot  <= abs_a;
              cnt   <= CNT_W'(WIDTH);
              state <= DIVIDE;
`endif
            end
          end
        end
        DIVIDE: begin
          if (!trial[WIDTH]) begin
            rem  <= trial[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
          end else begin
            rem  <= partial[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FINISH;
        end
        FINISH: if (ex_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && state == IDLE && enable_i && !is_div_op &&
        !(operator_i inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
                             ALU_SRA, ALU_EQ, ALU_NE, ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU,
                             ALU_SLTS, ALU_SLTU}))
      $warning("riscv_alu_seq: unsupported opcode %b", operator_i);
  end
`endif

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Directed self-checking bench for riscv_alu_seq at WIDTH=32.
module tb_riscv_alu_seq;

  localparam logic [6:0] OP_ADD  = 7'b0011000;
  localparam logic [6:0] OP_SUB  = 7'b0011001;
  localparam logic [6:0] OP_XOR  = 7'b0101111;
  localparam logic [6:0] OP_OR   = 7'b0101110;
  localparam logic [6:0] OP_AND  = 7'b0010101;
  localparam logic [6:0] OP_SRA  = 7'b0100100;
  localparam logic [6:0] OP_SRL  = 7'b0100101;
  localparam logic [6:0] OP_SLL  = 7'b0100111;
  localparam logic [6:0] OP_LTS  = 7'b0000000;
  localparam logic [6:0] OP_LTU  = 7'b0000001;
  localparam logic [6:0] OP_SLTS = 7'b0000010;
  localparam logic [6:0] OP_SLTU = 7'b0000011;
  localparam logic [6:0] OP_GES  = 7'b0001010;
  localparam logic [6:0] OP_GEU  = 7'b0001011;
  localparam logic [6:0] OP_EQ   = 7'b0001100;
  localparam logic [6:0] OP_NE   = 7'b0001101;
  localparam logic [6:0] OP_DIVU = 7'b0110000;
  localparam logic [6:0] OP_DIV  = 7'b0110001;
  localparam logic [6:0] OP_REMU = 7'b0110010;
  localparam logic [6:0] OP_REM  = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [6:0]  operator = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] result;
  logic        cmp;
  logic        ready;
  logic        ex_ready = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  riscv_alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(operator),
    .operand_a_i(operand_a), .operand_b_i(operand_b), .result_o(result),
    .comparison_result_o(cmp), .ready_o(ready), .ex_ready_i(ex_ready)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || result !== 32'h0 || cmp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ready=%b result=%h cmp=%b, want 1/00000000/0", ready, result, cmp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: ready=%b result=%h cmp=%b", ready, result, cmp);
  endtask

  task automatic test_single(input string name, input logic [6:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res, input logic exp_cmp);
    @(negedge clk);
    operator = op; operand_a = a; operand_b = b; enable = 1'b1;
    #1;
    n_checks++;
    if (result !== exp_res || cmp !== exp_cmp || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: result=%h cmp=%b ready=%b, want %h/%b/1", name, result, cmp, ready, exp_res, exp_cmp);
    end else
      $display("%s a=%h b=%h -> %h cmp=%b", name, a, b, result, cmp);
    @(negedge clk);
    enable = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL %s_idle: ready=%b result=%h, want 1/00000000", name, ready, result);
    end
  endtask

  task automatic test_div(input string name, input logic [6:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_cycles,
                          input int hold);
    int n;
    @(negedge clk);
    operator = op; operand_a = a; operand_b = b; enable = 1'b1;
    ex_ready = (hold == 0);
    #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: ready=%b, want 0", name, ready);
    end
    @(posedge clk);
    #1;
    // Inputs change while busy; the latched operation must be unaffected.
    operator = OP_ADD; operand_a = 32'h1234_5678; operand_b = 32'h0BAD_F00D;
    n = 1;
    forever begin
      @(negedge clk);
      if (ready === 1'b1 || n >= 100) break;
      n++;
    end
    n_checks++;
    if (n !== exp_cycles || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: cycles=%0d ready=%b, want %0d/1", name, n, ready, exp_cycles);
    end
    n_checks++;
    if (result !== exp_res) begin
      n_fail++;
      $display("FAIL %s_result: result=%h, want %h", name, result, exp_res);
    end
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      n_checks++;
      if (result !== exp_res || ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_hold%0d: result=%h ready=%b, want %h/1", name, i, result, ready, exp_res);
      end
    end
    ex_ready = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (result !== 32'h0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_idle: result=%h ready=%b, want 00000000/1", name, result, ready);
    end
    $display("%s a=%h b=%h -> %h after %0d cycles", name, a, b, exp_res, n);
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    operator = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd3; enable = 1'b1; ex_ready = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_busy: ready=%b, want 0", ready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset: ready=%b result=%h, want 1/00000000", ready, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-division: ready=%b result=%h", ready, result);
    test_div("divu_after_reset", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 0);
  endtask

  task automatic test_early_out();
`ifdef RISCV_ALU_DIV_EARLY_OUT_EN
    test_div("early_divu_6_3", OP_DIVU, 32'd6, 32'd3, 32'd2, 4, 0);
    test_div("early_divu_0_3", OP_DIVU, 32'd0, 32'd3, 32'd0, 1, 0);
`else
    test_div("divu_6_3", OP_DIVU, 32'd6, 32'd3, 32'd2, 33, 0);
    test_div("divu_0_3", OP_DIVU, 32'd0, 32'd3, 32'd0, 33, 0);
`endif
  endtask

  initial begin
    test_reset();
    test_single("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0);
    test_single("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
    test_single("and", OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0);
    test_single("or", OP_OR, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0);
    test_single("xor", OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0);
    test_single("sll_mask", OP_SLL, 32'h1, 32'h21, 32'h2, 1'b0);
    test_single("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    test_single("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    test_single("eq", OP_EQ, 32'd5, 32'd5, 32'hFFFF_FFFF, 1'b1);
    test_single("ne", OP_NE, 32'd5, 32'd5, 32'h0, 1'b0);
    test_single("lts", OP_LTS, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1);
    test_single("ltu", OP_LTU, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
    test_single("ges", OP_GES, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
    test_single("geu", OP_GEU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1);
    test_single("slts", OP_SLTS, 32'hFFFF_FFFF, 32'd1, 32'h1, 1'b1);
    test_single("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
    test_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    test_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    test_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    test_div("rem_m7_2_hold", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 5);
    test_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    test_div("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    test_div("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    test_div("divu_by_zero", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    test_div("rem_by_zero", OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
    test_reset_mid_div();
    test_early_out();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
